// File: rtl/apple_spawner.sv
// Apple manager for the snake playfield.
// Holds NUM_APPLES apple cells, answers renderer "apple here" queries and
// respawns eaten apples at pseudo-random free cells (LFSR + body scan).
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   eat_async         collision level from snake logic (asynchronous)
//   head              head cell {x,y}, sampled on the detected eat edge
//   body, body_len    flat body segment cells and number of valid segments
//   qx, qy            renderer query cell
//   apple             registered query result
//   apple_cells       current apple cells, slot i at [i*2*COORD_W +: 2*COORD_W]
//   apple_valid       per-slot valid
//   eaten             one-cycle pulse when a valid apple is consumed
//   busy              respawn FSM active
//   spawn_fail        sticky, set when a respawn exhausts MAX_TRIES
module apple_spawner #(
  parameter int unsigned COORD_W     = 4,
  parameter int unsigned GRID_W      = 16,
  parameter int unsigned GRID_H      = 16,
  parameter int unsigned MAX_LEN     = 50,
  parameter int unsigned NUM_APPLES  = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_TRIES   = 64,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [2*COORD_W-1:0] INIT_CELL = 8'hC5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              eat_async,
  input  logic [2*COORD_W-1:0]              head,
  input  logic [MAX_LEN*2*COORD_W-1:0]      body,
  input  logic [$clog2(MAX_LEN+1)-1:0]      body_len,
  input  logic [COORD_W-1:0]                qx,
  input  logic [COORD_W-1:0]                qy,
  output logic                              apple,
  output logic [NUM_APPLES*2*COORD_W-1:0]   apple_cells,
  output logic [NUM_APPLES-1:0]             apple_valid,
  output logic                              eaten,
  output logic                              busy,
  output logic                              spawn_fail
);

  localparam int unsigned CELL_W = 2 * COORD_W;
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);
  localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int unsigned SLOT_W = (NUM_APPLES > 1) ? $clog2(NUM_APPLES) : 1;
  localparam logic [NUM_APPLES*CELL_W-1:0] CELLS_RST = (NUM_APPLES*CELL_W)'(INIT_CELL);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {IDLE, PICK, SCAN, CHECK} state_t;

  state_t                  state_q, state_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [CELL_W-1:0]       cand_q, cand_d;
  logic [LEN_W-1:0]        idx_q, idx_d;
  logic [TRY_W-1:0]        tries_q, tries_d;
  logic [15:0]             lfsr_q;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    last_q;
  logic [NUM_APPLES-1:0]   pending_q;

  logic                    edge_c, hit_any_c, eat_hit_c;
  logic [SLOT_W-1:0]       hit_slot_c, need_slot_c;
  logic                    need_any_c, seg_hit_c, clash_c, query_c, in_range_c;
  logic                    commit_c, fail_set_c;

  // Rising edge on the synchronised collision level
  assign edge_c    = sync_q[SYNC_STAGES-1] & ~last_q;
  assign eat_hit_c = edge_c & hit_any_c;

  assign in_range_c = (32'(lfsr_q[CELL_W-1:COORD_W]) < GRID_W) &&
                      (32'(lfsr_q[COORD_W-1:0]) < GRID_H);

  // Slot lookups; descending loops so the lowest index wins
  always_comb begin
    hit_any_c   = 1'b0;
    hit_slot_c  = '0;
    need_any_c  = 1'b0;
    need_slot_c = '0;
    clash_c     = 1'b0;
    query_c     = 1'b0;
    for (int i = int'(NUM_APPLES) - 1; i >= 0; i--) begin
      if (apple_valid[i] && apple_cells[i*CELL_W +: CELL_W] == head) begin
        hit_any_c  = 1'b1;
        hit_slot_c = SLOT_W'(i);
      end
      if (!apple_valid[i] || pending_q[i]) begin
        need_any_c  = 1'b1;
        need_slot_c = SLOT_W'(i);
      end
      if (SLOT_W'(i) != slot_q && apple_valid[i] &&
          apple_cells[i*CELL_W +: CELL_W] == cand_q)
        clash_c = 1'b1;
      if (apple_valid[i] && apple_cells[i*CELL_W +: CELL_W] == {qx, qy})
        query_c = 1'b1;
    end
  end

  // Body segment at idx matches the candidate (live sample of body)
  always_comb begin
    seg_hit_c = 1'b0;
    for (int i = 0; i < int'(MAX_LEN); i++)
      if (LEN_W'(i) == idx_q && body[i*CELL_W +: CELL_W] == cand_q)
        seg_hit_c = 1'b1;
  end

  // Respawn FSM next-state and control
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    cand_d     = cand_q;
    idx_d      = idx_q;
    tries_d    = tries_q;
    commit_c   = 1'b0;
    fail_set_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (need_any_c && !spawn_fail) begin
          slot_d  = need_slot_c;
          state_d = PICK;
        end
      end
      PICK: begin
        if (tries_q == TRY_W'(MAX_TRIES)) begin
          fail_set_c = 1'b1;
          tries_d    = '0;
          state_d    = IDLE;
        end else begin
          cand_d  = lfsr_q[CELL_W-1:0];
          tries_d = tries_q + TRY_W'(1);
          if (in_range_c) begin
            idx_d   = '0;
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (idx_q == body_len)  state_d = CHECK;
        else if (seg_hit_c)     state_d = PICK;
        else                    idx_d   = idx_q + LEN_W'(1);
      end
      CHECK: begin
        if (clash_c) begin
          state_d = PICK;
        end else begin
          commit_c = 1'b1;
          tries_d  = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and spawn datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      cand_q  <= '0;
      idx_q   <= '0;
      tries_q <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cand_q  <= cand_d;
      idx_q   <= idx_d;
      tries_q <= tries_d;
      busy    <= (state_d != IDLE);
    end
  end

  // LFSR, synchroniser, apple slots and outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q      <= LFSR_SEED;
      sync_q      <= '0;
      last_q      <= 1'b0;
      apple_cells <= CELLS_RST;
      apple_valid <= NUM_APPLES'(1);
      pending_q   <= '0;
      eaten       <= 1'b0;
      spawn_fail  <= 1'b0;
      apple       <= 1'b0;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
      sync_q <= {sync_q[SYNC_STAGES-2:0], eat_async};
      last_q <= sync_q[SYNC_STAGES-1];
      eaten  <= eat_hit_c;
      apple  <= query_c;
      if (fail_set_c) spawn_fail <= 1'b1;
      // The spawning slot is invalid, so it can never be the eaten slot
      if (commit_c) begin
        apple_cells[slot_q*CELL_W +: CELL_W] <= cand_q;
        apple_valid[slot_q] <= 1'b1;
        pending_q[slot_q]   <= 1'b0;
      end
      if (eat_hit_c) begin
        apple_valid[hit_slot_c] <= 1'b0;
        pending_q[hit_slot_c]   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apple_spawner.sv
// Directed bench for apple_spawner: reset state, query, eat/respawn,
// forced body hit, back-to-back eats, retry exhaustion, mid-spawn reset.
module tb_apple_spawner;

  localparam int unsigned MAX_LEN = 50;
  localparam int unsigned LIMIT   = 64 * (MAX_LEN + 2);

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 eat_async = 1'b0;
  logic [7:0]           head = 8'h00;
  logic [MAX_LEN*8-1:0] body = '0;
  logic [5:0]           body_len = 6'd0;
  logic [3:0]           qx = 4'hC;
  logic [3:0]           qy = 4'h5;
  logic                 apple, eaten, busy, spawn_fail;
  logic [15:0]          apple_cells;
  logic [1:0]           apple_valid;

  // Second instance on a 7x7 board fully covered by the body
  logic                 eat_s = 1'b0;
  logic [7:0]           head_s = 8'h00;
  logic [MAX_LEN*8-1:0] body_s = '0;
  logic [5:0]           body_len_s = 6'd0;
  logic                 apple_s, eaten_s, busy_s, fail_s;
  logic [15:0]          cells_s;
  logic [1:0]           valid_s;

  int total = 0;
  int bad   = 0;
  int eat_cnt = 0;
  logic [15:0] lfsr_m;

  apple_spawner u_dut (
    .clk(clk), .reset(reset), .eat_async(eat_async), .head(head),
    .body(body), .body_len(body_len), .qx(qx), .qy(qy),
    .apple(apple), .apple_cells(apple_cells), .apple_valid(apple_valid),
    .eaten(eaten), .busy(busy), .spawn_fail(spawn_fail)
  );

  apple_spawner #(.GRID_W(7), .GRID_H(7), .INIT_CELL(8'h00)) u_small (
    .clk(clk), .reset(reset), .eat_async(eat_s), .head(head_s),
    .body(body_s), .body_len(body_len_s), .qx(qx), .qy(qy),
    .apple(apple_s), .apple_cells(cells_s), .apple_valid(valid_s),
    .eaten(eaten_s), .busy(busy_s), .spawn_fail(fail_s)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSR: x^16+x^14+x^13+x^11 Galois, free running from reset
  always @(posedge clk or negedge reset)
    if (!reset) lfsr_m <= 16'hACE1;
    else        lfsr_m <= lstep(lfsr_m);

  always @(negedge clk)
    if (eaten) eat_cnt <= eat_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] cell_of(input int i);
    return apple_cells[i*8 +: 8];
  endfunction

  function automatic logic in_body(input logic [7:0] c);
    for (int i = 0; i < int'(MAX_LEN); i++)
      if (i < int'(body_len) && body[i*8 +: 8] == c) return 1'b1;
    return 1'b0;
  endfunction

  // Wait until both slots are valid and the FSM is idle
  task automatic wait_done(input string tag);
    int n = 0;
    while (!(busy == 1'b0 && apple_valid == 2'b11) && n < int'(LIMIT)) begin
      tick();
      n++;
    end
    chk(tag, 32'({busy, apple_valid}), 32'(3'b011));
  endtask

  task automatic eat_slot0_start();
    head = cell_of(0);
    @(posedge clk);
    #1;
    eat_async = 1'b1;
  endtask

  initial begin
    logic [7:0] c;
    logic [7:0] s0, s1;
    int pulses, at, nb, n, e0;

    // Reset state
    #12;
    chk("rst_apple", 32'(apple), 32'(0));
    chk("rst_eaten", 32'(eaten), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_fail", 32'(spawn_fail), 32'(0));
    chk("rst_valid", 32'(apple_valid), 32'(2'b01));
    chk("rst_cell0", 32'(cell_of(0)), 32'(8'hC5));
    for (int x = 0; x < 7; x++)
      for (int y = 0; y < 7; y++)
        body_s[(x*7+y)*8 +: 8] = {4'(x), 4'(y)};
    body_len_s = 6'd49;

    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("query_init", 32'(apple), 32'(1));
    chk("spawn_busy", 32'(busy), 32'(1));

    // Retry limit cannot be reached this early
    repeat (30) tick();
    chk("small_no_early_fail", 32'(fail_s), 32'(0));
    wait_done("slot1_spawn_done");
    chk("slot1_ne_slot0", 32'(cell_of(1) != cell_of(0)), 32'(1));
    chk("no_fail", 32'(spawn_fail), 32'(0));
    n = 0;
    while (busy_s && n < int'(LIMIT)) begin
      tick();
      n++;
    end
    chk("small_idle", 32'(busy_s), 32'(0));
    chk("small_fail", 32'(fail_s), 32'(1));
    chk("small_valid", 32'(valid_s), 32'(2'b01));

    // Held eat level: one pulse, SYNC_STAGES+1 cycles after the rise
    body = '0;
    body[0 +: 8] = 8'h10; body[8 +: 8] = 8'h11;
    body[16 +: 8] = 8'h12; body[24 +: 8] = 8'h13;
    body_len = 6'd4;
    eat_slot0_start();
    pulses = 0; at = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (eaten) begin
        pulses++;
        at = k;
        chk("valid_cleared_on_eat", 32'(apple_valid[0]), 32'(0));
      end
    end
    eat_async = 1'b0;
    chk("eat_pulses", 32'(pulses), 32'(1));
    chk("eat_latency", 32'(at), 32'(3));
    wait_done("respawn0_done");
    chk("respawn0_not_body", 32'(in_body(cell_of(0))), 32'(0));
    chk("respawn0_ne_slot1", 32'(cell_of(0) != cell_of(1)), 32'(1));

    // Query: hit on new slot 0, miss on a cell with no apple
    {qx, qy} = cell_of(0);
    tick();
    chk("query_hit", 32'(apple), 32'(1));
    c = 8'h00;
    while (c == cell_of(0) || c == cell_of(1)) c = c + 8'h01;
    {qx, qy} = c;
    tick();
    chk("query_miss", 32'(apple), 32'(0));

    // First candidate placed at body[3]: SCAN must bounce back to PICK
    eat_slot0_start();
    tick(); tick(); tick();
    chk("eat2_pulse", 32'(eaten), 32'(1));
    eat_async = 1'b0;
    c = 8'(lstep(lfsr_m));
    body = '0;
    body[0 +: 8] = c ^ 8'h11; body[8 +: 8] = c ^ 8'h22;
    body[16 +: 8] = c ^ 8'h33; body[24 +: 8] = c;
    body[32 +: 8] = c ^ 8'h44;
    body_len = 6'd5;
    nb = 0; n = 0;
    tick();
    while (busy && n < int'(LIMIT)) begin
      nb++;
      tick();
      n++;
    end
    chk("scan_hit_retry", 32'(nb >= 13), 32'(1));
    chk("forced_valid", 32'(apple_valid), 32'(2'b11));
    chk("forced_ne_cand", 32'(cell_of(0) != c), 32'(1));
    chk("forced_not_body", 32'(in_body(cell_of(0))), 32'(0));
    chk("forced_ne_slot1", 32'(cell_of(0) != cell_of(1)), 32'(1));

    // Two eats four cycles apart, second one while busy
    s0 = cell_of(0); s1 = cell_of(1); e0 = eat_cnt;
    @(posedge clk);
    #1;
    head = s0; eat_async = 1'b1;
    tick(); tick();
    eat_async = 1'b0;
    tick(); tick();
    chk("busy_at_edge2", 32'(busy), 32'(1));
    head = s1; eat_async = 1'b1;
    tick(); tick();
    eat_async = 1'b0;
    tick(); tick();
    wait_done("double_done");
    tick();
    chk("double_pulses", 32'(eat_cnt - e0), 32'(2));
    chk("double_s0_not_body", 32'(in_body(cell_of(0))), 32'(0));
    chk("double_s1_not_body", 32'(in_body(cell_of(1))), 32'(0));
    chk("double_distinct", 32'(cell_of(0) != cell_of(1)), 32'(1));

    // Reset asserted while scanning
    eat_slot0_start();
    tick(); tick(); tick();
    eat_async = 1'b0;
    tick(); tick();
    chk("pre_rst_busy", 32'(busy), 32'(1));
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_valid", 32'(apple_valid), 32'(2'b01));
    chk("mid_rst_cell0", 32'(cell_of(0)), 32'(8'hC5));
    chk("mid_rst_eaten", 32'(eaten), 32'(0));
    chk("mid_rst_apple", 32'(apple), 32'(0));
    chk("mid_rst_fail", 32'(spawn_fail), 32'(0));
    @(negedge clk);
    reset = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
